// File: rtl/sid_mix.sv
// N-voice SID output mixer: one shared multiplier accumulates waveform*envelope per voice,
// then applies master volume and saturates to a signed output sample.
//
// state | meaning
// IDLE  | waiting for CLKen; snapshots inputs and clears the accumulator on the strobe
// MAC   | one voice per clock: acc += offset-corrected waveform * envelope
// SCALE | acc * volume / 16 (floor)
// OUT   | shift to output width, saturate, pulse VALID
module sid_mix #(
    parameter int VOICES  = 3,
    parameter int VOICE_W = 12,
    parameter int ENV_W   = 8,
    parameter int OUT_W   = 16
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic                        CLKen,
    input  logic [VOICES*VOICE_W-1:0]   VOICE,
    input  logic [VOICES*ENV_W-1:0]     ENV,
    input  logic [VOICES-1:0]           MUTE,
    input  logic [3:0]                  VOL,
    output logic signed [OUT_W-1:0]     OUTPUT,
    output logic                        VALID,
    output logic                        BUSY,
    output logic                        OVR
);

    localparam int PW    = VOICE_W + ENV_W;
    localparam int ACC_W = PW + $clog2(VOICES) + 1;
    localparam int SC_W  = ACC_W + 5;
    localparam int SH    = PW - OUT_W;
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    localparam logic signed [SC_W-1:0] SAT_MAX = {{(SC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SC_W-1:0] SAT_MIN = {{(SC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

    state_t state, state_nxt;

    logic [VOICES*VOICE_W-1:0] voice_q;
    logic [VOICES*ENV_W-1:0]   env_q;
    logic [VOICES-1:0]         mute_q;
    logic [3:0]                vol_q;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [SC_W-1:0]    sc_q;

    logic [VOICE_W-1:0]        voice_sel;
    logic signed [VOICE_W-1:0] vs;
    logic signed [ENV_W:0]     env_s;
    logic signed [PW:0]        prod;
    logic signed [SC_W-1:0]    scaled;
    logic signed [SC_W-1:0]    shifted;
    logic signed [OUT_W-1:0]   sat;
    logic                      last_idx;

    assign last_idx = (idx == IDX_W'(VOICES - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CLKen) state_nxt = MAC;
            MAC:     if (last_idx) state_nxt = SCALE;
            SCALE:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != IDLE);
    end

    // Shared multiplier: the selected voice is converted from offset-binary to two's complement.
    always_comb begin
        voice_sel = voice_q[idx*VOICE_W +: VOICE_W];
        vs        = {~voice_sel[VOICE_W-1], voice_sel[VOICE_W-2:0]};
        env_s     = {1'b0, env_q[idx*ENV_W +: ENV_W]};
        prod      = '0;
        if (!mute_q[idx]) begin
            prod = vs * env_s;
        end
    end

    assign scaled  = acc * $signed({1'b0, vol_q});
    assign shifted = sc_q >>> SH;

    always_comb begin
        sat = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            voice_q <= '0;
            env_q   <= '0;
            mute_q  <= '0;
            vol_q   <= '0;
            idx     <= '0;
            acc     <= '0;
            sc_q    <= '0;
            OUTPUT  <= '0;
            VALID   <= 1'b0;
            OVR     <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (CLKen && state != IDLE) begin
                OVR <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (CLKen) begin
                        voice_q <= VOICE;
                        env_q   <= ENV;
                        mute_q  <= MUTE;
                        vol_q   <= VOL;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= idx + 1'b1;
                end
                SCALE: begin
                    sc_q <= scaled >>> 4;
                end
                OUT: begin
                    OUTPUT <= sat;
                    VALID  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_mix.sv
// Randomised bench for sid_mix: an arithmetic reference model plus a per-cycle scoreboard,
// with directed mixes that pin known sample values, overrun behaviour and reset abort.
module tb_sid_mix;

    localparam int V  = 3;
    localparam int VW = 12;
    localparam int EW = 8;
    localparam int OW = 16;

    logic                   CLK = 1'b0;
    logic                   RSTn = 1'b0;
    logic                   CLKen = 1'b0;
    logic [V*VW-1:0]        VOICE = '0;
    logic [V*EW-1:0]        ENV = '0;
    logic [V-1:0]           MUTE = '0;
    logic [3:0]             VOL = '0;
    logic signed [OW-1:0]   OUTPUT;
    logic                   VALID;
    logic                   BUSY;
    logic                   OVR;

    sid_mix #(.VOICES(V), .VOICE_W(VW), .ENV_W(EW), .OUT_W(OW)) dut (
        .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen), .VOICE(VOICE), .ENV(ENV), .MUTE(MUTE),
        .VOL(VOL), .OUTPUT(OUTPUT), .VALID(VALID), .BUSY(BUSY), .OVR(OVR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sample value from the arithmetic definition: sum((v - 2^(VW-1)) * env), volume, shift, clamp.
    function automatic int model_mix(input logic [V*VW-1:0] v, input logic [V*EW-1:0] e,
                                     input logic [V-1:0] m, input logic [3:0] vol);
        longint acc, sc, r;
        acc = 0;
        for (int i = 0; i < V; i++) begin
            if (!m[i]) acc += (longint'(v[i*VW +: VW]) - (longint'(1) <<< (VW-1))) * longint'(e[i*EW +: EW]);
        end
        sc = (acc * longint'(vol)) >>> 4;
        r  = sc >>> (VW + EW - OW);
        if (r > (longint'(1) <<< (OW-1)) - 1) r = (longint'(1) <<< (OW-1)) - 1;
        if (r < -(longint'(1) <<< (OW-1)))    r = -(longint'(1) <<< (OW-1));
        return int'(r);
    endfunction

    int                     m_left;
    bit                     m_valid;
    bit                     m_ovr;
    logic signed [63:0]     m_held;
    int                     m_q[$];
    bit                     mon_en = 1'b0;

    always @(posedge CLK) begin
        bit was_busy;
        if (!RSTn) begin
            m_left  = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_held  = 0;
            m_q.delete();
        end else begin
            was_busy = (m_left > 0);
            m_valid  = 1'b0;
            if (CLKen) begin
                if (was_busy) m_ovr = 1'b1;
                else m_q.push_back(model_mix(VOICE, ENV, MUTE, VOL));
            end
            if (was_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    if (m_q.size() > 0) m_held = m_q.pop_front();
                end
            end else if (CLKen) begin
                m_left = V + 2;
            end
        end
        #1;
        if (mon_en) begin
            check("valid", VALID, m_valid);
            check("busy", BUSY, m_left > 0);
            check("ovr", OVR, m_ovr);
            check("output", OUTPUT, m_held);
        end
    end

    task automatic run_mix(input logic [V*VW-1:0] v, input logic [V*EW-1:0] e, input logic [V-1:0] m,
                           input logic [3:0] vol, input bit scramble, input int exp, input string name);
        int k;
        @(negedge CLK);
        VOICE = v; ENV = e; MUTE = m; VOL = vol; CLKen = 1'b1;
        @(negedge CLK);
        CLKen = 1'b0;
        if (scramble) begin
            VOICE = {$urandom, $urandom};
            ENV   = $urandom;
            MUTE  = $urandom;
            VOL   = $urandom;
        end
        for (k = 1; k <= 20; k++) begin
            @(posedge CLK);
            #2;
            if (VALID) break;
        end
        check({name, "_latency"}, k, V + 2);
        check(name, OUTPUT, exp);
    endtask

    logic [V*VW-1:0] v_fff, v_000, v_800, v_solo;
    logic [V*EW-1:0] e_ff, e_solo;

    initial begin
        v_fff  = {V{12'hFFF}};
        v_000  = {V{12'h000}};
        v_800  = {V{12'h800}};
        v_solo = {12'h800, 12'h800, 12'hFFF};
        e_ff   = {V{8'hFF}};
        e_solo = {8'h00, 8'h00, 8'hFF};

        check("model_solo", model_mix(v_solo, e_solo, 3'b000, 4'd15), 30585);
        check("model_sat_hi", model_mix(v_fff, e_ff, 3'b000, 4'd15), 32767);
        check("model_sat_lo", model_mix(v_000, e_ff, 3'b000, 4'd15), -32768);
        check("model_mute", model_mix(v_fff, e_ff, 3'b110, 4'd15), 30585);

        mon_en = 1'b1;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        run_mix(v_800, e_ff, 3'b000, 4'd15, 1'b0, 0, "midscale");
        run_mix(v_solo, e_solo, 3'b000, 4'd15, 1'b0, 30585, "solo_vol15");
        run_mix(v_solo, e_solo, 3'b000, 4'd0, 1'b0, 0, "solo_vol0");
        run_mix(v_fff, e_ff, 3'b000, 4'd15, 1'b0, 32767, "sat_hi");
        run_mix(v_000, e_ff, 3'b000, 4'd15, 1'b0, -32768, "sat_lo");
        run_mix(v_fff, e_ff, 3'b110, 4'd15, 1'b1, 30585, "mute_snapshot");

        // Overrun: second strobe two clocks into the mix.
        @(negedge CLK);
        check("ovr_before", OVR, 0);
        VOICE = v_solo; ENV = e_solo; MUTE = '0; VOL = 4'd15; CLKen = 1'b1;
        @(negedge CLK);
        CLKen = 1'b0;
        @(negedge CLK);
        VOICE = v_000; ENV = e_ff; CLKen = 1'b1;
        @(negedge CLK);
        CLKen = 1'b0;
        repeat (6) @(negedge CLK);
        check("ovr_set", OVR, 1);
        check("ovr_value", OUTPUT, 30585);
        run_mix(v_fff, e_ff, 3'b000, 4'd15, 1'b0, 32767, "after_ovr");
        check("ovr_sticky", OVR, 1);

        // Reset during MAC aborts the mix.
        @(negedge CLK);
        VOICE = v_000; ENV = e_ff; MUTE = '0; VOL = 4'd15; CLKen = 1'b1;
        @(negedge CLK);
        CLKen = 1'b0;
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check("rst_output", OUTPUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_valid", VALID, 0);
        check("rst_ovr", OVR, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);
        run_mix(v_solo, e_solo, 3'b000, 4'd15, 1'b0, 30585, "after_reset");

        // Random strobes and inputs changing every cycle, scored by the monitor.
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            CLKen = ($urandom_range(0, 3) == 0);
            VOICE = {$urandom, $urandom};
            ENV   = $urandom;
            MUTE  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : '0;
            VOL   = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
        end
        @(negedge CLK);
        CLKen = 1'b0;
        repeat (10) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sid_mix.md
Name: sid_mix

Overview:
- Parametrised successor to the three-voice SID output stage. Mixes N voices into one signed sample.
- Each voice's offset-binary waveform is multiplied by its envelope (multiplying-DAC model), and the products are accumulated.
- The sum is scaled by a 4-bit master volume, then shifted and saturated to the output width.
- A single time-multiplexed multiplier replaces per-voice multipliers. Sits between the voice/envelope generators and the audio output path.

Parameters:
- VOICES, 3, number of voices mixed (>=1)
- VOICE_W, 12, waveform width per voice (unsigned, offset-binary)
- ENV_W, 8, envelope width per voice (unsigned)
- OUT_W, 16, output sample width (signed); must be <= VOICE_W+ENV_W

Ports:
- CLK  in  1  master clock
- RSTn  in  1  asynchronous active-low reset
- CLKen  in  1  sample strobe, 1 MHz enable
- VOICE  in  VOICES*VOICE_W  packed waveforms; voice i at [i*VOICE_W +: VOICE_W]
- ENV  in  VOICES*ENV_W  packed envelopes; voice i at [i*ENV_W +: ENV_W]
- MUTE  in  VOICES  per-voice mute; 1 = voice contributes 0
- VOL  in  4  master volume, 0..15
- OUTPUT  out  OUT_W  signed mixed sample
- VALID  out  1  one-cycle pulse when OUTPUT updates
- BUSY  out  1  mix in progress
- OVR  out  1  sticky: CLKen arrived while BUSY

Behaviour:
- Reset: one clock, asynchronous active-low reset RSTn. While RSTn=0: OUTPUT=0, VALID=0, BUSY=0, OVR=0, state=IDLE, accumulator=0.
- Reset asserted mid-mix aborts the mix; no VALID is produced for that sample.
- States: IDLE, MAC, SCALE, OUT.
- IDLE:
  - On CLKen=1 (edge t0), snapshot VOICE, ENV, MUTE and VOL into internal registers.
  - Clear the accumulator, set index=0, BUSY=1, go to MAC.
  - Inputs are not sampled again until the next mix.
- MAC: one voice per clock, edges t1..tVOICES.
  - vs = {~v[VOICE_W-1], v[VOICE_W-2:0]}, treated as signed.
  - p = vs * signed({1'b0, env}), width VOICE_W+ENV_W; p=0 if the voice is muted.
  - acc += p. Accumulator width is VOICE_W+ENV_W+clog2(VOICES)+1, so it cannot overflow.
  - After index VOICES-1, go to SCALE.
- SCALE (edge tVOICES+1): sc = (acc * VOL) >>> 4, arithmetic shift (floor). VOL=0 gives 0; VOL=15 gives 15/16 gain.
- OUT (edge tVOICES+2):
  - r = sc >>> (VOICE_W+ENV_W-OUT_W).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register into OUTPUT.
  - VALID=1 for exactly this cycle; BUSY=0; go to IDLE.
- Latency: VALID is high in the cycle after edge t(VOICES+2); OUTPUT holds that value until the next OUT.
- Throughput: one sample per VOICES+3 clocks minimum.
- CLKen while BUSY=1, including the OUT cycle:
  - The strobe is ignored and OVR is set to 1.
  - The mix in progress completes unaffected.
  - OVR clears only on reset.
- CLKen on the cycle after OUT (IDLE) starts a new mix normally.
- Input changes during a mix do not affect that mix (snapshot rule).
- BUSY timing: high from the cycle after t0 through the cycle before VALID; low in the VALID cycle.

Test Plan:
- All voices 0x800, ENV=0xFF, VOL=15, MUTE=0, one CLKen -> exactly one VALID, 5 clocks after the strobe edge (VOICES=3); OUTPUT=0.
- Voice0=0xFFF/ENV 0xFF; voices1,2 ENV=0; VOL=15 -> acc=521985, sc=489360, OUTPUT=30585 (0x7779). Repeat with VOL=0 -> OUTPUT=0.
- All voices 0xFFF/ENV 0xFF, VOL=15 -> acc=1565955, r=91755, saturates to OUTPUT=32767. All voices 0x000/ENV 0xFF -> r=-91800, saturates to OUTPUT=-32768.
- All voices 0xFFF/ENV 0xFF, VOL=15, MUTE=3'b110 -> OUTPUT=30585. Change VOICE/VOL during MAC -> same result.
- Second CLKen 2 clocks after the first -> OVR=1; only one VALID, with the correct value. Next CLKen after idle -> normal mix; OVR stays 1.
- RSTn low during MAC -> OUTPUT=0, BUSY=0, no VALID. After release, a CLKen mix produces the correct value.
